// File: rtl/vga_scan_ctrl.sv
// VGA 640x480@60 scan timing and registered RGB444 output stage.
// Optional macro VGA_TEST_PATTERN_EN replaces color_in with an internal bar/border pattern.
module vga_scan_ctrl #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int CLK_DIV  = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [11:0] color_in,
    output logic [9:0]  x,
    output logic [8:0]  y,
    output logic        hs,
    output logic        vs,
    output logic [3:0]  r,
    output logic [3:0]  g,
    output logic [3:0]  b,
    output logic        active,
    output logic        frame_start
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [DIV_W-1:0] DIV_MAX  = DIV_W'(CLK_DIV - 1);
    localparam logic [9:0]       H_ACT_C  = 10'(H_ACTIVE);
    localparam logic [9:0]       H_LAST_C = 10'(H_TOTAL - 1);
    localparam logic [9:0]       HS_BEG_C = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0]       HS_END_C = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [9:0]       V_ACT_C  = 10'(V_ACTIVE);
    localparam logic [9:0]       V_LAST_C = 10'(V_TOTAL - 1);
    localparam logic [9:0]       VS_BEG_C = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0]       VS_END_C = 10'(V_ACTIVE + V_FP + V_SYNC - 1);

    logic [DIV_W-1:0] div_q, div_d;
    logic [9:0]       hcnt_q, hcnt_d;
    logic [9:0]       vcnt_q, vcnt_d;
    logic             hs_q, hs_d;
    logic             vs_q, vs_d;
    logic [3:0]       r_q, r_d;
    logic [3:0]       g_q, g_d;
    logic [3:0]       b_q, b_d;
    logic             active_q, active_d;
    logic             frame_start_q, frame_start_d;

    logic        tick;
    logic        h_vis;
    logic        v_vis;
    logic        vis_req;
    logic        hs_req;
    logic        vs_req;
    logic        h_wrap;
    logic        v_wrap;
    logic [11:0] pix_color;

    assign tick    = (div_q == DIV_MAX);
    assign h_vis   = (hcnt_q < H_ACT_C);
    assign v_vis   = (vcnt_q < V_ACT_C);
    assign vis_req = h_vis && v_vis;
    assign hs_req  = !((hcnt_q >= HS_BEG_C) && (hcnt_q <= HS_END_C));
    assign vs_req  = !((vcnt_q >= VS_BEG_C) && (vcnt_q <= VS_END_C));
    assign h_wrap  = (hcnt_q == H_LAST_C);
    assign v_wrap  = (vcnt_q == V_LAST_C);

    // Request coordinates are zeroed outside the visible area so y fits in 9 bits.
    assign x = h_vis ? hcnt_q : 10'd0;
    assign y = v_vis ? vcnt_q[8:0] : 9'd0;

`ifdef VGA_TEST_PATTERN_EN
    always_comb begin
        pix_color = 12'h000;
        case (x[9:7])
            3'd0: pix_color = 12'h000;
            3'd1: pix_color = 12'hF00;
            3'd2: pix_color = 12'h0F0;
            3'd3: pix_color = 12'h00F;
            3'd4: pix_color = 12'hFF0;
            3'd5: pix_color = 12'h0FF;
            3'd6: pix_color = 12'hF0F;
            3'd7: pix_color = 12'hFFF;
            default: pix_color = 12'h000;
        endcase
        if ((x == 10'd0) || (x == H_ACT_C - 10'd1) ||
            (y == 9'd0) || (y == 9'(V_ACTIVE - 1))) begin
            pix_color = 12'hFFF;
        end
    end
`else
    assign pix_color = color_in;
`endif

    // Everything but the divider holds between ticks; frame_start self-clears after one clk.
    always_comb begin
        div_d         = tick ? '0 : div_q + DIV_W'(1);
        hcnt_d        = hcnt_q;
        vcnt_d        = vcnt_q;
        hs_d          = hs_q;
        vs_d          = vs_q;
        r_d           = r_q;
        g_d           = g_q;
        b_d           = b_q;
        active_d      = active_q;
        frame_start_d = 1'b0;
        if (tick) begin
            hcnt_d = h_wrap ? 10'd0 : hcnt_q + 10'd1;
            if (h_wrap) begin
                vcnt_d = v_wrap ? 10'd0 : vcnt_q + 10'd1;
            end
            hs_d          = hs_req;
            vs_d          = vs_req;
            active_d      = vis_req;
            r_d           = vis_req ? pix_color[11:8] : 4'd0;
            g_d           = vis_req ? pix_color[7:4]  : 4'd0;
            b_d           = vis_req ? pix_color[3:0]  : 4'd0;
            frame_start_d = h_wrap && v_wrap;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            div_q         <= '0;
            hcnt_q        <= 10'd0;
            vcnt_q        <= 10'd0;
            hs_q          <= 1'b1;
            vs_q          <= 1'b1;
            r_q           <= 4'd0;
            g_q           <= 4'd0;
            b_q           <= 4'd0;
            active_q      <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            div_q         <= div_d;
            hcnt_q        <= hcnt_d;
            vcnt_q        <= vcnt_d;
            hs_q          <= hs_d;
            vs_q          <= vs_d;
            r_q           <= r_d;
            g_q           <= g_d;
            b_q           <= b_d;
            active_q      <= active_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign hs          = hs_q;
    assign vs          = vs_q;
    assign r           = r_q;
    assign g           = g_q;
    assign b           = b_q;
    assign active      = active_q;
    assign frame_start = frame_start_q;

endmodule
